hamming_secded_encoder_tx: RTL and testbench
============================================

# hamming_secded_encoder_tx

Streaming SECDED (8,4) encoder for the Tang 9K Hamming datapath. Accepts 4-bit data nibbles over a valid/ready handshake and computes the 8-bit codeword in the bit layout that the downstream syndrome checker consumes. Buffers the codeword in a 2-entry output FIFO and counts delivered words. Sits between the board's data source (switches/UART) and the channel/decoder side.

## Interface
- No parameters; widths are fixed by the (8,4) code.
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `in_data`  in  4  data nibble {d3,d2,d1,d0}
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block can accept a nibble this cycle
- `inj_mask`  in  8  error-injection XOR mask, sampled with the accepted nibble (used only with `HAMMING_ERR_INJECT_EN`)
- `out_data`  out  8  codeword cw[7:0] at FIFO head
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer takes `out_data` this cycle
- `tx_count`  out  16  number of codewords delivered

## Operation
- Bit layout of the codeword:
  - cw[3]=d0, cw[5]=d1, cw[6]=d2, cw[7]=d3
  - cw[2]=d0^d1^d3, cw[1]=d0^d2^d3, cw[4]=d1^d2^d3
  - cw[0]=^cw[7:1], making overall parity even
- This layout yields checks cw{2,3,5,7}, cw{1,3,6,7} and cw{4,5,6,7} all zero, and XOR over all 8 bits zero, for any error-free word.
- Input handshake: a beat transfers on a rising edge with `in_valid && in_ready`. Encoding is combinational on `in_data`. The codeword (optionally XORed with `inj_mask`) is written to the FIFO tail on that edge.
- Output FIFO: depth 2, with a `count` register of 0..2.
  - `in_ready = !rst && count != 2`
  - `out_valid = count != 0`
  - `out_data` = head entry, or 8'h00 when empty.
- Simultaneous push and pop:
  - count unchanged; head advances and the new word is written.
  - With count=1, the pushed word becomes the head on the next cycle.
  - Pop without `out_valid` is ignored.
  - Push is impossible when full, because `in_ready` is low.
- `tx_count` increments on each `out_valid && out_ready` edge and wraps 0xFFFF→0x0000.
- The output side is stall-safe: while `out_valid && !out_ready`, `out_data` holds stable.

## Timing
- Reset values (asynchronous, immediate on `rst` high):
  - count=0, FIFO pointers=0, `out_valid`=0, `out_data`=8'h00, `tx_count`=0, `in_ready`=0.
  - `in_ready` rises in the first cycle after `rst` deasserts.
- Latency: a nibble accepted at edge N appears on `out_data` with `out_valid`=1 in the cycle after edge N when the FIFO was empty.
- Throughput: 1 word/cycle while `out_ready` is held high.
- Full backpressure: after 2 accepted words with `out_ready`=0, `in_ready`=0. It returns to 1 the cycle after the first pop.
- Reset mid-operation discards all FIFO contents and clears `tx_count`. No partial word is emitted afterwards.
- No combinational path from `out_ready` to `in_ready`.

## Configuration
- `HAMMING_ERR_INJECT_EN` defined:
  - Stored codeword = encoded word ^ `inj_mask`, with `inj_mask` sampled on the accepting edge.
  - Used on the board to exercise single-error correction and double-error detection downstream.
- Undefined:
  - `inj_mask` is ignored (no logic depends on it) and codewords are always clean.
  - Port list is identical in both builds.

## Test plan
- Reset then encode, `out_ready`=1:
  - `in_data` 4'h0→8'h00
  - 4'hB→8'hAC
  - 4'h1→8'h0F
  - 4'hF→8'hFF
  - each arrives 1 cycle after acceptance.
- Exhaustive: all 16 nibbles. For every output, XOR of cw{2,3,5,7}, cw{1,3,6,7}, cw{4,5,6,7} and of all 8 bits is 0, and data bits cw[7,6,5,3] equal {d3,d2,d1,d0}.
- Backpressure, `out_ready`=0:
  - push 4'hB, 4'h1 → `in_ready`=0 with `out_data`=8'hAC stable.
  - raise `out_ready` → 8'hAC then 8'h0F in order, and `in_ready`=1 one cycle after the first pop.
- Simultaneous push/pop at count=1 for 8 cycles: no word lost or duplicated, order preserved, and `tx_count` advances by exactly the number of pops.
- With `HAMMING_ERR_INJECT_EN`:
  - 4'hB with `inj_mask`=8'h08 → 8'hA4.
  - mask 8'h81 → 8'h2D.
  - Without the macro, the same stimulus → 8'hAC.
- Assert `rst` with 2 words buffered → `out_valid`=0 and `tx_count`=0 immediately. After release, first output is the next accepted word. Preload `tx_count` to 0xFFFF, deliver one word → 0x0000.

Source files
------------

// File: rtl/hamming_secded_encoder_tx.sv
// rtl/hamming_secded_encoder_tx.sv - streaming SECDED (8,4) encoder with 2-entry output FIFO
// Optional build macro: HAMMING_ERR_INJECT_EN (XOR inj_mask into the stored codeword)
module hamming_secded_encoder_tx (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  inj_mask,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] tx_count
);

    logic [7:0]  enc_word;
    logic [7:0]  wr_word;
    logic        push;
    logic        pop;

    logic [7:0]  mem0_q, mem0_d;
    logic [7:0]  mem1_q, mem1_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [15:0] tx_count_q, tx_count_d;

    // Bit positions match the downstream syndrome checker's layout.
    always_comb begin
        enc_word    = 8'h00;
        enc_word[3] = in_data[0];
        enc_word[5] = in_data[1];
        enc_word[6] = in_data[2];
        enc_word[7] = in_data[3];
        enc_word[2] = in_data[0] ^ in_data[1] ^ in_data[3];
        enc_word[1] = in_data[0] ^ in_data[2] ^ in_data[3];
        enc_word[4] = in_data[1] ^ in_data[2] ^ in_data[3];
        enc_word[0] = ^enc_word[7:1];
    end

`ifdef HAMMING_ERR_INJECT_EN
    assign wr_word = enc_word ^ inj_mask;
`else
    logic unused_inj_mask;
    assign unused_inj_mask = ^inj_mask;
    assign wr_word = enc_word;
`endif

    assign in_ready  = !rst && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = out_valid ? (rd_ptr_q ? mem1_q : mem0_q) : 8'h00;
    assign tx_count  = tx_count_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        mem0_d     = mem0_q;
        mem1_d     = mem1_q;
        wr_ptr_d   = wr_ptr_q ^ push;
        rd_ptr_d   = rd_ptr_q ^ pop;
        count_d    = count_q + {1'b0, push} - {1'b0, pop};
        tx_count_d = tx_count_q + {15'd0, pop};
        if (push) begin
            if (wr_ptr_q) begin
                mem1_d = wr_word;
            end else begin
                mem0_d = wr_word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0_q     <= 8'h00;
            mem1_q     <= 8'h00;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            tx_count_q <= 16'h0000;
        end else begin
            mem0_q     <= mem0_d;
            mem1_q     <= mem1_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_count_q <= tx_count_d;
        end
    end

endmodule

// File: tb/tb_hamming_secded_encoder_tx.sv
// tb/tb_hamming_secded_encoder_tx.sv - self-checking bench for hamming_secded_encoder_tx
module tb_hamming_secded_encoder_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  inj_mask;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] tx_count;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb[$];
    logic [15:0] exp_tx = 16'h0000;
    logic        check_props = 1'b0;
    logic [15:0] tx0;
    logic [7:0]  exp_a, exp_b;
    logic [7:0]  head;
    int          n;

    hamming_secded_encoder_tx dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inj_mask  (inj_mask),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tx_count  (tx_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] encode(input logic [3:0] d);
        logic [7:0] c;
        c    = 8'h00;
        c[3] = d[0];
        c[5] = d[1];
        c[6] = d[2];
        c[7] = d[3];
        c[2] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[4] = d[1] ^ d[2] ^ d[3];
        c[0] = c[7] ^ c[6] ^ c[5] ^ c[4] ^ c[3] ^ c[2] ^ c[1];
        return c;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: decide transfers from stable mid-cycle values, pop before push.
    always @(negedge clk) begin
        if (!rst) begin
            chk("tx_count_track", tx_count, exp_tx);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 16'(sb.size()), 16'd1);
                end else begin
                    head = sb.pop_front();
                    chk("out_data_sb", {8'h00, out_data}, {8'h00, head});
                end
                if (check_props) begin
                    chk("syn_p1", {15'd0, out_data[2] ^ out_data[3] ^ out_data[5] ^ out_data[7]}, 16'd0);
                    chk("syn_p2", {15'd0, out_data[1] ^ out_data[3] ^ out_data[6] ^ out_data[7]}, 16'd0);
                    chk("syn_p4", {15'd0, out_data[4] ^ out_data[5] ^ out_data[6] ^ out_data[7]}, 16'd0);
                    chk("overall_parity", {15'd0, ^out_data}, 16'd0);
                end
                exp_tx = exp_tx + 16'd1;
            end
            if (in_valid && in_ready) begin
`ifdef HAMMING_ERR_INJECT_EN
                sb.push_back(encode(in_data) ^ inj_mask);
`else
                sb.push_back(encode(in_data));
`endif
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_data   = 4'h0;
        in_valid  = 1'b0;
        inj_mask  = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_data", {8'h00, out_data}, 16'h0000);
        chk("rst_tx_count", tx_count, 16'h0000);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", {15'd0, in_ready}, 16'd1);

        // Directed encodes with one-cycle latency.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data = 4'h0; cyc(); chk("enc_0_valid", {15'd0, out_valid}, 16'd1); chk("enc_0", {8'h00, out_data}, 16'h0000);
        in_data = 4'hB; cyc(); chk("enc_B", {8'h00, out_data}, 16'h00AC);
        in_data = 4'h1; cyc(); chk("enc_1", {8'h00, out_data}, 16'h000F);
        in_data = 4'hF; cyc(); chk("enc_F", {8'h00, out_data}, 16'h00FF);
        in_valid = 1'b0;
        cyc();
        chk("drain_empty", {15'd0, out_valid}, 16'd0);

        // All nibbles; data bits checked directly, parity checks in the monitor.
        check_props = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 4'(i);
            cyc();
            chk("exh_data_bits", {12'd0, out_data[7], out_data[6], out_data[5], out_data[3]}, 16'(i));
        end
        in_valid = 1'b0;
        cyc();
        check_props = 1'b0;

        // Full backpressure.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 4'hB; cyc();
        in_data = 4'h1; cyc();
        in_valid = 1'b0;
        chk("bp_in_ready_low", {15'd0, in_ready}, 16'd0);
        chk("bp_head", {8'h00, out_data}, 16'h00AC);
        cyc(); cyc();
        chk("bp_head_stable", {8'h00, out_data}, 16'h00AC);
        chk("bp_valid_stable", {15'd0, out_valid}, 16'd1);
        out_ready = 1'b1;
        cyc();
        chk("bp_in_ready_back", {15'd0, in_ready}, 16'd1);
        chk("bp_second", {8'h00, out_data}, 16'h000F);
        cyc();
        chk("bp_drained", {15'd0, out_valid}, 16'd0);

        // Simultaneous push/pop with one word resident.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'h3;
        cyc();
        tx0 = tx_count;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 4'(i + 4);
            cyc();
            chk("pp_valid", {15'd0, out_valid}, 16'd1);
            chk("pp_in_ready", {15'd0, in_ready}, 16'd1);
            chk("pp_head", {8'h00, out_data}, {8'h00, encode(4'(i + 4))});
        end
        chk("pp_tx_delta", tx_count - tx0, 16'd8);
        in_valid = 1'b0;
        cyc();
        chk("pp_empty", {15'd0, out_valid}, 16'd0);
        chk("pp_sb_empty", 16'(sb.size()), 16'd0);

        // Error injection (clean codeword in the default build).
`ifdef HAMMING_ERR_INJECT_EN
        exp_a = 8'hA4;
        exp_b = 8'h2D;
`else
        exp_a = 8'hAC;
        exp_b = 8'hAC;
`endif
        in_valid = 1'b1;
        in_data  = 4'hB;
        inj_mask = 8'h08; cyc(); chk("inj_08", {8'h00, out_data}, {8'h00, exp_a});
        inj_mask = 8'h81; cyc(); chk("inj_81", {8'h00, out_data}, {8'h00, exp_b});
        in_valid = 1'b0;
        inj_mask = 8'h00;
        cyc();

        // Reset with two words buffered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data = 4'h5; cyc();
        in_data = 4'h6; cyc();
        in_valid = 1'b0;
        chk("mid_full", {15'd0, in_ready}, 16'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        chk("mid_rst_tx", tx_count, 16'h0000);
        chk("mid_rst_ready", {15'd0, in_ready}, 16'd0);
        chk("mid_rst_data", {8'h00, out_data}, 16'h0000);
        sb.delete();
        exp_tx = 16'h0000;
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'h1;
        cyc();
        in_valid = 1'b0;
        chk("post_rst_first", {8'h00, out_data}, 16'h000F);
        cyc();
        chk("post_rst_empty", {15'd0, out_valid}, 16'd0);

        // Stream until tx_count reaches 0xFFFF, then one more delivery wraps it.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (exp_tx != 16'hFFFF && n < 70000) begin
            in_data = 4'(n);
            cyc();
            n++;
            if (exp_tx == 16'hFFFF) begin
                in_valid  = 1'b0;
                out_ready = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("wrap_reached", exp_tx, 16'hFFFF);
        chk("wrap_pre", tx_count, 16'hFFFF);
        chk("wrap_pending", {15'd0, out_valid}, 16'd1);
        out_ready = 1'b1;
        cyc();
        chk("wrap_zero", tx_count, 16'h0000);
        repeat (3) cyc();
        chk("final_empty", {15'd0, out_valid}, 16'd0);
        chk("final_sb_empty", 16'(sb.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
